muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 141 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply-accumulate / restoring divide sequencer.
// One shift step per cycle; SETUP takes magnitudes, FIX restores the sign and writes P.
module muldiv_sequencer #(
    parameter int W     = 26,
    parameter int CNT_W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DB_IN,
    output logic [W-1:0] DB_OUT,
    output logic         DB_OE,
    input  logic         LDX,
    input  logic         LDY,
    input  logic         LDZ,
    input  logic         IS_DIV,
    input  logic         MD_START,
    input  logic         MD_RST,
    input  logic         OUTPUT_PQ,
    output logic         MD_IS_ACTIVE,
    output logic         MD_DONE,
    output logic         DIV_ZERO
);

    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] x_reg, y_reg, z_reg, p_reg;
    logic [W-1:0]        mag_x, mag_y, acc, q;
    logic [CNT_W-1:0]    cnt;
    logic                is_div, neg_res, div_zero;
    logic                last_step;

    logic [W:0]          rem_shift;
    logic [W-1:0]        acc_step, q_step;

    function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    assign last_step = (cnt == CNT_W'(W - 1));

    // Multiply consumes the multiplier MSB-first from q; divide shifts the
    // dividend out of q into the remainder while quotient bits shift in.
    always_comb begin
        rem_shift = {acc, q[W-1]};
        q_step    = {q[W-2:0], 1'b0};
        acc_step  = {acc[W-2:0], 1'b0} + (q[W-1] ? mag_x : '0);
        if (is_div) begin
            if (rem_shift >= {1'b0, mag_y}) begin
                acc_step  = rem_shift[W-1:0] - mag_y;
                q_step[0] = 1'b1;
            end else begin
                acc_step  = rem_shift[W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (MD_RST) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (MD_START) state_nxt = SETUP;
                SETUP:   state_nxt = ITER;
                ITER:    if (last_step) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || MD_RST) begin
            x_reg    <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
            p_reg    <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LDX) x_reg <= DB_IN;
                    if (LDY) y_reg <= DB_IN;
                    if (LDZ) z_reg <= DB_IN;
                    if (MD_START) begin
                        is_div   <= IS_DIV;
                        div_zero <= 1'b0;
                    end
                end
                SETUP: begin
                    mag_x   <= abs_mag(x_reg);
                    mag_y   <= abs_mag(y_reg);
                    neg_res <= x_reg[W-1] ^ y_reg[W-1];
                    acc     <= '0;
                    q       <= is_div ? abs_mag(x_reg) : abs_mag(y_reg);
                    cnt     <= '0;
                end
                ITER: begin
                    acc <= acc_step;
                    q   <= q_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_div && mag_y == '0) begin
                        p_reg    <= '1;
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        p_reg <= apply_sign(q, neg_res);
                    end else begin
                        p_reg <= apply_sign(acc, neg_res) + z_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low during reset and an aborting MD_RST cannot produce a done pulse.
    assign MD_IS_ACTIVE = !RST && (state != IDLE);
    assign MD_DONE      = !RST && !MD_RST && (state == FIX);
    assign DB_OE        = !RST && OUTPUT_PQ && (state == IDLE);
    assign DB_OUT       = DB_OE ? p_reg : '0;
    assign DIV_ZERO     = !RST && div_zero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: multiply-accumulate, signed divide,
// divide-by-zero, soft abort and strobe blocking while active.
module tb_muldiv_sequencer;

    localparam int W = 26;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] DB_IN = '0;
    logic [W-1:0] DB_OUT;
    logic         DB_OE;
    logic         LDX = 1'b0, LDY = 1'b0, LDZ = 1'b0;
    logic         IS_DIV = 1'b0, MD_START = 1'b0, MD_RST = 1'b0, OUTPUT_PQ = 1'b0;
    logic         MD_IS_ACTIVE, MD_DONE, DIV_ZERO;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_sequencer #(.W(W), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .LDX(LDX), .LDY(LDY), .LDZ(LDZ), .IS_DIV(IS_DIV), .MD_START(MD_START),
        .MD_RST(MD_RST), .OUTPUT_PQ(OUTPUT_PQ), .MD_IS_ACTIVE(MD_IS_ACTIVE),
        .MD_DONE(MD_DONE), .DIV_ZERO(DIV_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic load_xyz(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        @(negedge CLK); DB_IN = x; LDX = 1'b1;
        @(negedge CLK); LDX = 1'b0; DB_IN = y; LDY = 1'b1;
        @(negedge CLK); LDY = 1'b0; DB_IN = z; LDZ = 1'b1;
        @(negedge CLK); LDZ = 1'b0; DB_IN = '0;
    endtask

    // Starts an operation and counts active/done cycles until idle (bounded).
    // inject_at: cycle index at which MD_START, LDX(0x1234) and OUTPUT_PQ are pulsed.
    // abort_at: cycle index at which MD_RST is pulsed.
    task automatic run_op(input logic div, input int inject_at, input int abort_at,
                          output int act, output int dn, output logic oe_seen);
        logic finished;
        act = 0; dn = 0; oe_seen = 1'b0;
        @(negedge CLK); MD_START = 1'b1; IS_DIV = div;
        @(negedge CLK); MD_START = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == inject_at) begin
                MD_START = 1'b1; LDX = 1'b1; DB_IN = 26'h1234; OUTPUT_PQ = 1'b1;
            end
            if (i == abort_at) MD_RST = 1'b1;
            #1;
            if (DB_OE) oe_seen = 1'b1;
            if (MD_IS_ACTIVE) act++;
            if (MD_DONE) dn++;
            finished = !MD_IS_ACTIVE;
            @(negedge CLK);
            MD_START = 1'b0; LDX = 1'b0; DB_IN = '0; OUTPUT_PQ = 1'b0; MD_RST = 1'b0;
            if (finished) break;
        end
    endtask

    task automatic read_p(output logic [W-1:0] val, output logic oe);
        OUTPUT_PQ = 1'b1;
        #1;
        val = DB_OUT;
        oe  = DB_OE;
        OUTPUT_PQ = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        logic oe;
        int waited;
        @(negedge CLK);
        DB_IN = 26'h155; LDX = 1'b1; LDY = 1'b1; LDZ = 1'b1;
        MD_START = 1'b1; MD_RST = 1'b1; OUTPUT_PQ = 1'b1;
        @(negedge CLK); #1;
        tests_run++;
        if (DB_OE !== 1'b0 || DB_OUT !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: oe=%b out=%h required oe=0 out=0", DB_OE, DB_OUT);
        end
        tests_run++;
        if (MD_IS_ACTIVE !== 1'b0 || MD_DONE !== 1'b0 || DIV_ZERO !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: active=%b done=%b dz=%b required 0/0/0", MD_IS_ACTIVE, MD_DONE, DIV_ZERO);
        end
        @(negedge CLK);
        LDX = 1'b0; LDY = 1'b0; LDZ = 1'b0; MD_RST = 1'b0; OUTPUT_PQ = 1'b0; DB_IN = '0;
        RST = 1'b0; MD_START = 1'b1; IS_DIV = 1'b0;
        @(negedge CLK); MD_START = 1'b0; #1;
        tests_run++;
        if (MD_IS_ACTIVE !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_start: active=%b required 1", MD_IS_ACTIVE);
        end
        waited = 0;
        while (MD_IS_ACTIVE && waited < 40) begin
            @(negedge CLK); #1;
            waited++;
        end
        read_p(v, oe);
        tests_run++;
        if (v !== '0 || oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_regs_result: got %h oe=%b required 0000000 oe=1", v, oe);
        end
    endtask

    task automatic test_mul_basic();
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        load_xyz(26'd3, 26'd5, 26'd0);
        run_op(1'b0, -1, -1, act, dn, oe_seen);
        tests_run++;
        if (act != 28) begin
            tests_failed++;
            $display("FAIL mul_active_cycles: got %0d required 28", act);
        end
        tests_run++;
        if (dn != 1) begin
            tests_failed++;
            $display("FAIL mul_done_pulses: got %0d required 1", dn);
        end
        read_p(v, oe);
        tests_run++;
        if (v !== 26'h000000F || oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_3x5: got %h oe=%b required 000000f oe=1", v, oe);
        end
    endtask

    task automatic test_mul_acc();
        logic [W-1:0] xs [5] = '{26'd6, 26'h3FFFFFF, 26'h1000000, 26'h3FFFFFD, 26'd3};
        logic [W-1:0] ys [5] = '{26'd7, 26'd2,       26'd4,       26'h3FFFFFB, 26'd3};
        logic [W-1:0] zs [5] = '{26'd100, 26'd0,     26'd0,       26'h3FFFFEC, 26'd3};
        logic [W-1:0] ex [5] = '{26'h000008E, 26'h3FFFFFE, 26'h0000000, 26'h3FFFFFB, 26'h000000C};
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                @(negedge CLK); DB_IN = xs[k]; LDX = 1'b1; LDY = 1'b1; LDZ = 1'b1;
                @(negedge CLK); LDX = 1'b0; LDY = 1'b0; LDZ = 1'b0; DB_IN = '0;
            end else begin
                load_xyz(xs[k], ys[k], zs[k]);
            end
            run_op(1'b0, -1, -1, act, dn, oe_seen);
            read_p(v, oe);
            tests_run++;
            if (v !== ex[k]) begin
                tests_failed++;
                $display("FAIL mul_acc_%0d: got %h required %h", k, v, ex[k]);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] xs [4] = '{26'h3FFFFF9, 26'd100,     26'h2000000, 26'h3FFFF9C};
        logic [W-1:0] ys [4] = '{26'd2,       26'h3FFFFF9, 26'h3FFFFFF, 26'h3FFFFF6};
        logic [W-1:0] ex [4] = '{26'h3FFFFFD, 26'h3FFFFF2, 26'h2000000, 26'h000000A};
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        for (int k = 0; k < 4; k++) begin
            load_xyz(xs[k], ys[k], 26'd0);
            run_op(1'b1, -1, -1, act, dn, oe_seen);
            read_p(v, oe);
            tests_run++;
            if (v !== ex[k] || DIV_ZERO !== 1'b0 || act != 28 || dn != 1) begin
                tests_failed++;
                $display("FAIL div_%0d: got %h dz=%b act=%0d done=%0d required %h dz=0 act=28 done=1",
                         k, v, DIV_ZERO, act, dn, ex[k]);
            end
        end
    endtask

    task automatic test_div_zero();
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        load_xyz(26'd9, 26'd0, 26'd0);
        run_op(1'b1, -1, -1, act, dn, oe_seen);
        read_p(v, oe);
        tests_run++;
        if (v !== 26'h3FFFFFF || DIV_ZERO !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_zero_result: got %h dz=%b required 3ffffff dz=1", v, DIV_ZERO);
        end
        load_xyz(26'd3, 26'd5, 26'd0);
        repeat (3) @(negedge CLK);
        #1;
        tests_run++;
        if (DIV_ZERO !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_zero_sticky: dz=%b required 1", DIV_ZERO);
        end
        run_op(1'b0, -1, -1, act, dn, oe_seen);
        read_p(v, oe);
        tests_run++;
        if (DIV_ZERO !== 1'b0 || v !== 26'h000000F) begin
            tests_failed++;
            $display("FAIL div_zero_clear: dz=%b p=%h required dz=0 p=000000f", DIV_ZERO, v);
        end
    endtask

    task automatic test_md_rst();
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        // index 0 is SETUP, so index 11 is ITER cycle 10
        run_op(1'b0, -1, 11, act, dn, oe_seen);
        tests_run++;
        if (act != 12 || dn != 0) begin
            tests_failed++;
            $display("FAIL md_rst_abort: act=%0d done=%0d required act=12 done=0", act, dn);
        end
        read_p(v, oe);
        tests_run++;
        if (v !== '0 || oe !== 1'b1 || MD_IS_ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("FAIL md_rst_clear: p=%h oe=%b active=%b required p=0 oe=1 active=0", v, oe, MD_IS_ACTIVE);
        end
        run_op(1'b0, -1, -1, act, dn, oe_seen);
        read_p(v, oe);
        tests_run++;
        if (act != 28 || dn != 1 || v !== '0) begin
            tests_failed++;
            $display("FAIL md_rst_rerun: act=%0d done=%0d p=%h required act=28 done=1 p=0", act, dn, v);
        end
    endtask

    task automatic test_ignore_while_active();
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        load_xyz(26'd6, 26'd7, 26'd1);
        run_op(1'b0, 5, -1, act, dn, oe_seen);
        read_p(v, oe);
        tests_run++;
        if (act != 28 || dn != 1 || oe_seen !== 1'b0 || v !== 26'h000002B) begin
            tests_failed++;
            $display("FAIL ignore_active: act=%0d done=%0d oe_seen=%b p=%h required 28/1/0/000002b",
                     act, dn, oe_seen, v);
        end
        run_op(1'b0, -1, -1, act, dn, oe_seen);
        read_p(v, oe);
        tests_run++;
        if (v !== 26'h000002B) begin
            tests_failed++;
            $display("FAIL ignore_x_kept: p=%h required 000002b", v);
        end
    endtask

    task automatic test_back_to_back();
        int act, dn;
        logic oe_seen, oe;
        logic [W-1:0] v;
        int extra;
        load_xyz(26'd3, 26'd5, 26'd0);
        // index 27 is the FIX cycle, where MD_DONE pulses
        run_op(1'b0, 27, -1, act, dn, oe_seen);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (MD_IS_ACTIVE) extra++;
            @(negedge CLK);
        end
        read_p(v, oe);
        tests_run++;
        if (act != 28 || dn != 1 || extra != 0 || v !== 26'h000000F) begin
            tests_failed++;
            $display("FAIL start_at_done: act=%0d done=%0d restart_cycles=%0d p=%h required 28/1/0/000000f",
                     act, dn, extra, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_acc();
        test_div();
        test_div_zero();
        test_md_rst();
        test_ignore_while_active();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
